store_narrow_unit: RTL and testbench
====================================

Name: store_narrow_unit

Overview:
Store-side counterpart to the immediate/load-data widening path in the multicycle CPU. It takes a 32-bit register value (rt) and narrows it to byte, halfword or word width for SB/SH/SW. Byte and halfword stores need a read-modify-write on the word-wide data memory, so the block runs that sequence with a ready handshake. It sits between the datapath's MEM stage and the data memory port, and the main control FSM stalls on Busy.

Parameters:
WAIT_LIMIT, 15, max cycles to wait for MemReady in one access before aborting with Error; 0 = wait forever
ADDR_W, 32, byte address width

Ports:
CLK  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
Start  input  1  request pulse; sampled only in IDLE
Size  input  2  0=byte, 1=halfword, 2=word, 3=illegal
Addr  input  ADDR_W  byte address of the store
DataIn  input  32  register value to store; low bits are used for byte/half
Busy  output  1  high from the cycle after an accepted Start until the return to IDLE
Done  output  1  one-cycle pulse: store completed
Error  output  1  one-cycle pulse: misaligned/illegal request or timeout
MemAddr  output  ADDR_W  word address {Addr[ADDR_W-1:2],2'b00}
MemRead  output  1  read request, held until MemReady
MemWrite  output  1  write request, held until MemReady
MemWData  output  32  write data
MemRData  input  32  read data, valid when MemReady and MemRead
MemReady  input  1  memory completes the current access this cycle

Behaviour:
- Reset (synchronous, active-high): state=IDLE. Busy, Done, Error, MemRead, MemWrite=0. MemAddr, MemWData, latched regs, wait counter=0. Reset mid-operation abandons the access; no further MemRead/MemWrite is issued.
- States: IDLE, READ, MERGE, WRITE, DONE, ERR.
- IDLE: on Start, latch Size, Addr, DataIn. Start is ignored in any other state.
  - Misaligned or illegal (Size=3; Size=1 with Addr[0]=1; Size=2 with Addr[1:0]!=0) -> ERR. No memory access is made.
  - Size=2 -> WRITE with MemWData=DataIn.
  - Size=0/1 -> READ.
- READ: MemRead=1. On MemReady, latch MemRData -> MERGE.
- MERGE (1 cycle): big-endian lane insert into the latched word.
  - Byte at offset k=Addr[1:0]: replace bits [31-8k : 24-8k] with DataIn[7:0].
  - Half at Addr[1]=0: bits [31:16]; at Addr[1]=1: bits [15:0]; value is DataIn[15:0].
  - Other bits are unchanged. Next state is WRITE.
- WRITE: MemWrite=1 with MemWData stable. On MemReady -> DONE.
- DONE: Done=1 for one cycle -> IDLE.
- ERR: Error=1 for one cycle -> IDLE.
- Wait counter: cleared on entry to READ and WRITE; increments each cycle MemReady=0. If WAIT_LIMIT!=0 and the counter reaches WAIT_LIMIT, drop the request -> ERR.
- MemRead and MemWrite are never high together. MemAddr is constant from READ through WRITE.
- Latency with MemReady tied 1, Start at cycle N:
  - word: WRITE at N+1, Done at N+2
  - byte/half: READ N+1, MERGE N+2, WRITE N+3, Done N+4
- Busy=1 in every state except IDLE. Done and Error never assert in the same cycle.

Test Plan:
- SW, Addr=0x100, DataIn=0xDEADBEEF, MemReady=1 -> MemWrite at N+1 with MemAddr=0x100, MemWData=0xDEADBEEF; Done at N+2; no MemRead.
- SB, Addr=0x102, DataIn=0x000000AB, MemRData=0x11223344 -> write 0x1122AB44 at MemAddr=0x100; Done at N+4.
- SH, Addr=0x106, DataIn=0xFFFF5566, MemRData=0xAABBCCDD, MemReady delayed 3 cycles per access -> write 0xAABB5566; MemRead/MemWrite held during the stall; Done once.
- SH at Addr=0x101 and SW at Addr=0x102 -> Error pulse at N+1; MemRead and MemWrite stay 0. A Start pulsed while Busy is ignored.
- WAIT_LIMIT=4, MemReady held 0 in READ -> Error after 4 wait cycles, MemRead drops, return to IDLE.
- Reset asserted in WRITE during a stall -> next cycle all outputs 0, state IDLE; a following SB completes normally.

Source files
------------

// File: rtl/store_narrow_unit.sv
// Store narrowing unit: SB/SH/SW to a word-wide data memory.
// Byte and halfword stores run a read-modify-write with a ready handshake and a wait-limit timeout.
module store_narrow_unit #(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Start,
  input  logic [1:0]        Size,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [31:0]       DataIn,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [31:0]       MemWData,
  input  logic [31:0]       MemRData,
  input  logic              MemReady
);

  typedef enum logic [2:0] {StIdle, StRead, StMerge, StWrite, StDone, StErr} state_e;

  localparam logic [31:0] LimitM1 = WAIT_LIMIT - 1;

  state_e            state_q, state_d;
  logic              half_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       data_q;
  logic [31:0]       wdata_q;
  logic [31:0]       cnt_q;
  logic [31:0]       merged;
  logic              bad_req;
  logic              timeout;

  assign bad_req = (Size == 2'd3) || ((Size == 2'd1) && Addr[0]) ||
                   ((Size == 2'd2) && (Addr[1:0] != 2'd0));
  assign timeout = (WAIT_LIMIT != 0) && !MemReady && (cnt_q == LimitM1);

  // Big-endian lane insert: byte offset 0 is the most significant byte.
  always_comb begin
    merged = wdata_q;
    if (half_q) begin
      if (addr_q[1]) merged[15:0] = data_q;
      else           merged[31:16] = data_q;
    end else begin
      unique case (addr_q[1:0])
        2'd0: merged[31:24] = data_q[7:0];
        2'd1: merged[23:16] = data_q[7:0];
        2'd2: merged[15:8]  = data_q[7:0];
        2'd3: merged[7:0]   = data_q[7:0];
        default: merged = wdata_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          if (bad_req)              state_d = StErr;
          else if (Size == 2'd2)    state_d = StWrite;
          else                      state_d = StRead;
        end
      end
      StRead: begin
        if (MemReady)     state_d = StMerge;
        else if (timeout) state_d = StErr;
      end
      StMerge: state_d = StWrite;
      StWrite: begin
        if (MemReady)     state_d = StDone;
        else if (timeout) state_d = StErr;
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= StIdle;
      half_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (Start) begin
            half_q  <= (Size == 2'd1);
            addr_q  <= Addr;
            data_q  <= DataIn[15:0];
            wdata_q <= DataIn;
          end
        end
        StRead:  if (MemReady) wdata_q <= MemRData;
        StMerge: wdata_q <= merged;
        default: ;
      endcase
      // Counter is zero whenever an access begins, since READ/WRITE are entered from other states.
      if (((state_q == StRead) || (state_q == StWrite)) && !MemReady) cnt_q <= cnt_q + 32'd1;
      else                                                             cnt_q <= '0;
    end
  end

  assign Busy     = (state_q != StIdle);
  assign Done     = (state_q == StDone);
  assign Error    = (state_q == StErr);
  assign MemRead  = (state_q == StRead);
  assign MemWrite = (state_q == StWrite);
  assign MemAddr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign MemWData = wdata_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Self-checking bench for store_narrow_unit: per-cycle trace model plus literal pins.
module tb_store_narrow_unit;

  localparam int Limit = 4;

  logic        CLK = 1'b0;
  logic        Reset, Start, Busy, Done, Error, MemRead, MemWrite, MemReady;
  logic [1:0]  Size;
  logic [31:0] Addr, DataIn, MemAddr, MemWData, MemRData;

  store_narrow_unit #(.WAIT_LIMIT(Limit), .ADDR_W(32)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Size(Size), .Addr(Addr), .DataIn(DataIn),
    .Busy(Busy), .Done(Done), .Error(Error), .MemAddr(MemAddr), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemWData(MemWData), .MemRData(MemRData), .MemReady(MemReady)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        busy, done, error, rd, wr, chk_addr, chk_wdata;
    logic [31:0] addr, wdata;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0, errors = 0;
  int          cyc = 0, start_cyc = 0;
  int          done_cnt, err_cnt, rd_cnt, wr_cnt, done_off, err_off;
  logic [31:0] wr_val;
  logic [31:0] mem_rdata;
  int          mem_delay;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic busy, done, error, rd, wr,
                              input logic [31:0] addr, wdata, input logic ca, cw);
    exp_t e;
    e.busy = busy; e.done = done; e.error = error; e.rd = rd; e.wr = wr;
    e.addr = addr; e.wdata = wdata; e.chk_addr = ca; e.chk_wdata = cw;
    return e;
  endfunction

  // Expected per-cycle outputs from cycle N (Start high) until back in idle.
  task automatic gen(input logic [1:0] sz, input logic [31:0] a, d, rd, input int dly,
                     input int rst_at);
    exp_t        t[$];
    logic [31:0] wa, w, mask;
    logic [1:0]  lo;
    int          sh, n;
    bit          bad, ok;
    wa  = {a[31:2], 2'b00};
    lo  = a[1:0];
    bad = (sz == 2'd3) || (sz == 2'd1 && lo[0]) || (sz == 2'd2 && lo != 2'd0);
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    w  = d;
    ok = 1;
    if (bad) begin
      t.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
      ok = 0;
    end else if (sz != 2'd2) begin
      n = (dly >= Limit) ? Limit : dly + 1;
      for (int i = 0; i < n; i++) t.push_back(mk(1, 0, 0, 1, 0, wa, 0, 1, 0));
      if (dly >= Limit) begin
        t.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
        ok = 0;
      end else begin
        if (sz == 2'd0) begin
          sh   = 8 * (3 - int'(lo));
          mask = 32'hFF << sh;
          w    = (rd & ~mask) | ({24'h0, d[7:0]} << sh);
        end else begin
          sh   = 16 * (1 - int'(lo[1]));
          mask = 32'hFFFF << sh;
          w    = (rd & ~mask) | ({16'h0, d[15:0]} << sh);
        end
        t.push_back(mk(1, 0, 0, 0, 0, wa, 0, 1, 0));
      end
    end
    if (ok) begin
      n = (dly >= Limit) ? Limit : dly + 1;
      for (int i = 0; i < n; i++) t.push_back(mk(1, 0, 0, 0, 1, wa, w, 1, 1));
      if (dly >= Limit) t.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
      else              t.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
    end
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (rst_at > 0) begin
      while (t.size() > rst_at + 1) void'(t.pop_back());
      t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    foreach (t[i]) exp_q.push_back(t[i]);
  endtask

  // Memory responder: ready after mem_delay stall cycles of each access.
  initial begin
    int acc;
    acc = 0;
    MemReady = 1'b0;
    MemRData = 32'h0;
    forever begin
      @(posedge CLK);
      #2;
      if (MemRead || MemWrite) begin
        MemReady = (acc >= mem_delay);
        acc++;
      end else begin
        MemReady = 1'b0;
        acc = 0;
      end
      MemRData = MemReady ? mem_rdata : 32'h0;
    end
  end

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    exp_t e;
    if (Done)  begin done_cnt++; done_off = cyc - start_cyc; end
    if (Error) begin err_cnt++;  err_off  = cyc - start_cyc; end
    if (MemRead) rd_cnt++;
    if (MemWrite && MemReady) begin wr_cnt++; wr_val = MemWData; end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("busy", {31'h0, Busy}, {31'h0, e.busy});
      check("done", {31'h0, Done}, {31'h0, e.done});
      check("error", {31'h0, Error}, {31'h0, e.error});
      check("mem_read", {31'h0, MemRead}, {31'h0, e.rd});
      check("mem_write", {31'h0, MemWrite}, {31'h0, e.wr});
      if (e.chk_addr)  check("mem_addr", MemAddr, e.addr);
      if (e.chk_wdata) check("mem_wdata", MemWData, e.wdata);
    end
  end

  task automatic run(input logic [1:0] sz, input logic [31:0] a, d, rd, input int dly,
                     input bit ghost, input int rst_at);
    int k;
    @(posedge CLK); #1;
    Start = 1'b1; Size = sz; Addr = a; DataIn = d;
    mem_rdata = rd; mem_delay = dly; start_cyc = cyc;
    done_cnt = 0; err_cnt = 0; rd_cnt = 0; wr_cnt = 0; done_off = -1; err_off = -1;
    wr_val = 32'h0;
    gen(sz, a, d, rd, dly, rst_at);
    k = 0;
    while (exp_q.size() > 0 && k < 80) begin
      @(posedge CLK); #1;
      k++;
      if (ghost && k == 2) begin
        Start = 1'b1; Size = 2'd2; Addr = 32'h200; DataIn = 32'h12345678;
      end else begin
        Start = 1'b0;
      end
      Reset = (rst_at != 0 && k == rst_at);
    end
    Start = 1'b0;
    Reset = 1'b0;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL trace_timeout remaining=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Size = 2'd0; Addr = 32'h0; DataIn = 32'h0;
    mem_rdata = 32'h0; mem_delay = 0;
    @(posedge CLK); #1;
    repeat (2) exp_q.push_back(mk(0, 0, 0, 0, 0, 32'h0, 32'h0, 1, 1));
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    Reset = 1'b0;

    run(2'd2, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 0);
    check("sw_done_off", done_off, 2);
    check("sw_wdata", wr_val, 32'hDEADBEEF);
    check("sw_reads", rd_cnt, 0);

    run(2'd0, 32'h102, 32'h000000AB, 32'h11223344, 0, 1, 0);
    check("sb_done_off", done_off, 4);
    check("sb_wdata", wr_val, 32'h1122AB44);
    check("sb_writes", wr_cnt, 1);

    run(2'd1, 32'h106, 32'hFFFF5566, 32'hAABBCCDD, 3, 0, 0);
    check("sh_wdata", wr_val, 32'hAABB5566);
    check("sh_done_cnt", done_cnt, 1);
    check("sh_done_off", done_off, 10);

    run(2'd1, 32'h101, 32'h1234, 32'h0, 0, 0, 0);
    check("sh_mis_err_off", err_off, 1);
    check("sh_mis_mem", rd_cnt + wr_cnt, 0);

    run(2'd2, 32'h102, 32'h1234, 32'h0, 0, 0, 0);
    check("sw_mis_err_off", err_off, 1);
    check("sw_mis_done", done_cnt, 0);

    run(2'd3, 32'h100, 32'h1234, 32'h0, 0, 0, 0);
    check("illegal_err_cnt", err_cnt, 1);

    run(2'd0, 32'h203, 32'h00000055, 32'hFFFFFFFF, 1, 0, 0);
    check("sb3_wdata", wr_val, 32'hFFFFFF55);
    run(2'd1, 32'h300, 32'h00001234, 32'h0, 0, 0, 0);
    check("sh0_wdata", wr_val, 32'h12340000);
    run(2'd0, 32'h400, 32'h000000C3, 32'h0, 2, 0, 0);
    check("sb0_wdata", wr_val, 32'hC3000000);

    run(2'd0, 32'h104, 32'hAB, 32'h0, 99, 0, 0);
    check("to_err_off", err_off, 5);
    check("to_reads", rd_cnt, 4);
    check("to_writes", wr_cnt, 0);

    run(2'd2, 32'h500, 32'hCAFEF00D, 32'h0, 99, 0, 2);
    check("rst_done", done_cnt, 0);
    check("rst_err", err_cnt, 0);

    run(2'd0, 32'h102, 32'h000000AB, 32'h11223344, 0, 0, 0);
    check("post_rst_done_off", done_off, 4);
    check("post_rst_wdata", wr_val, 32'h1122AB44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
